// File: rtl/scan_sequencer.sv
// Index scan sequencer: steps a 3-bit select index through up, down, ping-pong or
// one-shot patterns at a programmable prescaled rate, with registered outputs.
module scan_sequencer #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] period,
  output logic [2:0]            idx,
  output logic                  step,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;
  localparam logic [1:0] MODE_ONCE = 2'b11;

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [2:0]            idx_q, idx_d;
  logic                  dir_up_q, dir_up_d;
  logic                  step_q, step_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_UP;
      period_q <= '0;
      presc_q  <= '0;
      idx_q    <= 3'd0;
      dir_up_q <= 1'b1;
      step_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      dir_up_q <= dir_up_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    period_d = period_q;
    presc_d  = presc_q;
    idx_d    = idx_q;
    dir_up_d = dir_up_q;
    step_d   = 1'b0;
    done_d   = 1'b0;

    if (state_q == IDLE) begin
      // stop beats a coincident start; idx keeps its last value in that case
      if (start && !stop) begin
        state_d  = RUN;
        mode_d   = mode;
        period_d = period;
        presc_d  = '0;
        idx_d    = (mode == MODE_DOWN) ? 3'd7 : 3'd0;
        dir_up_d = 1'b1;
      end
    end else begin
      if (stop) begin
        state_d = IDLE;
      end else if (en) begin
        if (presc_q == period_q) begin
          presc_d = '0;
          step_d  = 1'b1;
          case (mode_q)
            MODE_UP:   idx_d = idx_q + 3'd1;
            MODE_DOWN: idx_d = idx_q - 3'd1;
            MODE_PING: begin
              // turn around at the ends so no endpoint is visited twice in a row
              if (dir_up_q) begin
                if (idx_q == 3'd7) begin
                  dir_up_d = 1'b0;
                  idx_d    = 3'd6;
                end else begin
                  idx_d = idx_q + 3'd1;
                end
              end else begin
                if (idx_q == 3'd0) begin
                  dir_up_d = 1'b1;
                  idx_d    = 3'd1;
                end else begin
                  idx_d = idx_q - 3'd1;
                end
              end
            end
            MODE_ONCE: begin
              if (idx_q == 3'd7) begin
                state_d = IDLE;
                step_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                idx_d = idx_q + 3'd1;
              end
            end
            default: idx_d = idx_q;
          endcase
        end else begin
          presc_d = presc_q + PRESCALE_W'(1);
        end
      end
    end

    busy_d = (state_d == RUN);
  end

  assign idx  = idx_q;
  assign step = step_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: a driver feeds stimulus and a tick-count
// reference model; a monitor pops expected outputs once per clock and compares.
module tb_scan_sequencer;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [PW-1:0] period = '0;
  logic [2:0]    idx;
  logic          step, busy, done;

  scan_sequencer #(.PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en),
    .mode(mode), .period(period), .idx(idx), .step(step), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] idx;
    logic       step;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_txn = 0;

  // Reference model: the scan is described by how many ticks have elapsed.
  bit m_run = 0;
  int m_mode = 0, m_period = 0, m_cnt = 0, m_n = 0, m_idx = 0;
  bit m_step = 0, m_done = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic int idx_of(input int md, input int n);
    int p;
    case (md)
      0: return n % 8;
      1: return 7 - (n % 8);
      2: begin
        p = n % 14;
        return (p <= 7) ? p : 14 - p;
      end
      default: return n;
    endcase
  endfunction

  function automatic bit tick_next(input bit e);
    return m_run && e && (m_cnt == m_period);
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit sp, input bit e,
                            input int md, input int pd);
    m_step = 0;
    m_done = 0;
    if (r) begin
      m_run = 0; m_mode = 0; m_period = 0; m_cnt = 0; m_n = 0; m_idx = 0;
    end else if (!m_run) begin
      if (s && !sp) begin
        m_run = 1; m_mode = md; m_period = pd; m_cnt = 0; m_n = 0;
        m_idx = idx_of(md, 0);
      end
    end else if (sp) begin
      m_run = 0;
    end else if (e) begin
      if (m_cnt == m_period) begin
        m_cnt = 0;
        if (m_mode == 3 && m_n == 7) begin
          m_run  = 0;
          m_done = 1;
        end else begin
          m_n++;
          m_idx  = idx_of(m_mode, m_n);
          m_step = 1;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic push_exp();
    exp_t x;
    x.idx  = 3'(m_idx);
    x.step = m_step;
    x.busy = m_run;
    x.done = m_done;
    exp_q.push_back(x);
  endtask

  task automatic cyc(input bit r, input bit s, input bit sp, input bit e,
                     input logic [1:0] md, input logic [PW-1:0] pd);
    @(negedge clk);
    rst = r; start = s; stop = sp; en = e; mode = md; period = pd;
    model_edge(r, s, sp, e, int'(md), int'(pd));
    push_exp();
  endtask

  task automatic run_cycles(input int n, input bit e);
    for (int i = 0; i < n; i++)
      cyc(0, 1'($urandom_range(0, 1)), 0, e, 2'($urandom), PW'($urandom));
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    start = 0; stop = 0; en = 1;
    rst = 1;
    #1;
    check("async_rst_idx", idx, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_step", step, 0);
    check("async_rst_done", done, 0);
    model_edge(1, 0, 0, 0, 0, 0);
    push_exp();
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_txn++;
      $display("txn %0d: idx=%0d step=%0d busy=%0d done=%0d", n_txn, idx, step, busy, done);
      check("idx", idx, mon_e.idx);
      check("step", step, mon_e.step);
      check("busy", busy, mon_e.busy);
      check("done", done, mon_e.done);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    #1 rst = 1;
    #1;
    check("reset_idx", idx, 0);
    check("reset_busy", busy, 0);
    check("reset_step", step, 0);
    check("reset_done", done, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 0, 0);

    $display("scenario: mode 00 period 2, start/mode/period toggled in RUN");
    cyc(0, 1, 0, 1, 2'b00, 2);
    run_cycles(30, 1);
    cyc(0, 0, 1, 1, 0, 0);

    $display("scenario: start+stop in IDLE");
    cyc(0, 1, 1, 1, 2'b01, 0);
    repeat (2) cyc(0, 0, 0, 1, 0, 0);

    $display("scenario: mode 10 period 0");
    cyc(0, 1, 0, 1, 2'b10, 0);
    repeat (20) cyc(0, 0, 0, 1, 2'b10, 0);
    cyc(0, 0, 1, 1, 0, 0);

    $display("scenario: mode 11 period 0");
    cyc(0, 1, 0, 1, 2'b11, 0);
    repeat (12) cyc(0, 0, 0, 1, 2'b11, 0);

    $display("scenario: mode 01 period 1 with en pause");
    cyc(0, 1, 0, 1, 2'b01, 1);
    repeat (6) cyc(0, 0, 0, 1, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);

    $display("scenario: stop on a tick cycle");
    cyc(0, 1, 0, 1, 2'b00, 3);
    repeat (6) cyc(0, 0, 0, 1, 0, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (tick_next(1)) begin
        cyc(0, 0, 1, 1, 0, 0);
        found = 1;
      end else begin
        cyc(0, 0, 0, 1, 0, 0);
      end
    end
    check("stop_tick_found", found, 1);
    repeat (2) cyc(0, 0, 0, 1, 0, 0);

    $display("scenario: async reset at idx 5");
    cyc(0, 1, 0, 1, 2'b00, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_idx == 5) found = 1;
      else cyc(0, 0, 0, 1, 0, 0);
    end
    check("reach_idx5", found, 1);
    async_reset();
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 2'b11, 1);
    repeat (20) cyc(0, 0, 0, 1, 0, 0);

    $display("scenario: random traffic");
    for (int i = 0; i < 300; i++)
      cyc(0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 3) != 0), 2'($urandom), PW'($urandom_range(0, 3)));

    repeat (2) cyc(0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
